// File: rtl/native_ahb_bridge.sv
// native_ahb_bridge
//   Converts a simple native memory request (valid/ready handshake) into a
//   single AHB-Lite NONSEQ transfer. Each transfer passes through
//   IDLE -> ADDR -> DATA -> DONE. All AHB and native outputs are registered.
//
// Ports
//   HCLK, HRESETn            clock (rising edge), async active-low reset
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb
//                            native request (wstrb == 0 means read)
//   mem_ready/mem_rdata      native response (one-cycle ready pulse)
//   HADDR..HWDATA            AHB-Lite master outputs
//   HRDATA/HREADY/HRESP      AHB-Lite master inputs
//   bus_err/err_addr/err_clr sticky error flag, last errored address, clear
module native_ahb_bridge #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
  parameter bit          PRIV      = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] wdata_q;
  logic [1:0]  req_lsb;
  logic [2:0]  req_size;
  logic        unused_addr_lsb;

  // Byte lanes come from the strobes, not the core address.
  assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_valid) state_nxt = ADDR;
      ADDR:    if (HREADY)    state_nxt = DATA;
      DATA:    if (HREADY)    state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Transfer size and low address bits derived from the write strobes.
  always_comb begin
    req_lsb  = 2'b00;
    req_size = 3'b010;
    case (mem_wstrb)
      4'b0001: begin req_size = 3'b000; req_lsb = 2'd0; end
      4'b0010: begin req_size = 3'b000; req_lsb = 2'd1; end
      4'b0100: begin req_size = 3'b000; req_lsb = 2'd2; end
      4'b1000: begin req_size = 3'b000; req_lsb = 2'd3; end
      4'b0011: begin req_size = 3'b001; req_lsb = 2'd0; end
      4'b1100: begin req_size = 3'b001; req_lsb = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HTRANS    <= 2'b00;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      HPROT     <= 4'b0000;
      HWDATA    <= '0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      // Placed before the state case so an error completing this cycle wins.
      if (err_clr) bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            HTRANS  <= 2'b10;
            HADDR   <= {mem_addr[ADDR_W-1:2], req_lsb};
            HWRITE  <= (mem_wstrb != 4'b0000);
            HSIZE   <= req_size;
            HPROT   <= {2'b00, PRIV, ~mem_instr};
            wdata_q <= mem_wdata;
          end
        end
        ADDR: begin
          if (HREADY) begin
            HTRANS <= 2'b00;
            HWDATA <= wdata_q;
          end
        end
        DATA: begin
          if (HREADY) begin
            mem_ready <= 1'b1;
            if (HRESP) begin
              bus_err  <= 1'b1;
              err_addr <= HADDR;
              if (!HWRITE) mem_rdata <= ERR_RDATA;
            end else if (!HWRITE) begin
              mem_rdata <= HRDATA;
            end
          end
        end
        DONE: mem_ready <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
